decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, 8, width of data/address field and Data output.
REQ-002 Parameter NUM_REGS, 4, register count; power of two, 2..16; RSEL_W = clog2(NUM_REGS).
REQ-003 Parameter DM_WR_LAT, 1, data-memory write latency in cycles; 1..7.
REQ-004 Derived INS_W = 5 + RSEL_W + DATA_W; Ins fields, MSB first: opcode[4:0] (section = top 2 bits, rest = low 3 bits), RNum[RSEL_W-1:0], Data[DATA_W-1:0]; fields do not overlap.
REQ-005 Clk  in  1  single clock; all state on rising edge.
REQ-006 Rst  in  1  synchronous, active-high reset.
REQ-007 Ins  in  INS_W  instruction word.
REQ-008 InValid  in  1  Ins valid.
REQ-009 InReady  out  1  decoder accepts Ins this cycle.
REQ-010 Flush  in  1  discard held decoded instruction.
REQ-011 OutValid  out  1  decoded bundle valid.
REQ-012 OutReady  in  1  downstream accepts bundle.
REQ-013 DataMem_WE, Reg_CE, Carry_CE, Accu_CE  out  1 each  enables; forced 0 while OutValid=0.
REQ-014 RegAddr  out  NUM_REGS  one-hot register select.
REQ-015 Data  out  DATA_W  immediate / data-memory address.
REQ-016 SelDataSource  out  2  operand source (SEC_R, SEC_DM, SEC_IMD).
REQ-017 ALUCode  out  3  ALU operation.
REQ-018 IllegalOp  out  1  held instruction is undefined (qualified by OutValid).
REQ-019 HazardStall  out  1  InReady is low this cycle because of a DM read-after-write hazard.

Function
REQ-020 Decode: sections 0-2 with rest <= ALU_NOT -> ALUCode=rest, SelDataSource=section, Accu_CE=1, Carry_CE=1 iff rest <= ALU_SUB; sections 0-2 with rest > ALU_NOT -> IllegalOp=1.
REQ-021 Section 3: rest 0 LD_R (SEC_R), 1 LD_DM (SEC_DM), 2 LD_IMD (SEC_IMD) -> ALUCode=ALU_LD, Accu_CE=1; rest 3 ST_R (SEC_DM, Reg_CE=1), 4 ST_DM (SEC_R, DataMem_WE=1) -> ALUCode=ALU_DEF; rest 5-7 -> IllegalOp=1.
REQ-022 Illegal instructions: all enables 0, ALUCode=ALU_DEF, SelDataSource=SEC_R, passed downstream as a bundle.
REQ-023 RegAddr = one-hot(RNum); Data = Ins data field, unmodified.
REQ-024 One output register stage; latency 1 cycle from accepted Ins to OutValid.
REQ-025 InReady = (!OutValid | OutReady) & !Flush & !hazard; Ins loaded when InValid & InReady.
REQ-026 OutValid: set on load; cleared when OutValid & OutReady without load; cleared next cycle on Flush (Flush wins over load).
REQ-027 Bundle held stable while OutValid & !OutReady.
REQ-028 DM read = section SEC_DM, or LD_DM.
REQ-029 Pending store: on handshake of an ST_DM bundle, PendCnt <= DM_WR_LAT, PendAddr <= Data; otherwise PendCnt decrements to 0 (saturating).
REQ-030 hazard = InValid & Ins is DM read & ((PendCnt != 0 & addr == PendAddr) | (OutValid & held ST_DM & addr == held Data)); HazardStall = hazard.
REQ-031 Store handshaking in the same cycle as a same-address read: hazard asserted, read accepted only after PendCnt reaches 0.
REQ-032 Flush does not clear PendCnt/PendAddr; a flushed ST_DM never loads PendCnt.

Reset
REQ-033 Rst: OutValid=0, all bundle registers 0 (RegAddr=0), IllegalOp=0, PendCnt=0, PendAddr=0; InReady=0 during Rst.
REQ-034 Rst mid-operation discards held bundle and pending-store state; first acceptance on the cycle after Rst deasserts.

Structure
REQ-035 Shared package holds SEC_R/SEC_DM/SEC_IMD/SEC_REST, ALU_ADD..ALU_NOT, ALU_LD, ALU_DEF, section-3 rest codes, LAST_LD_INS, and a decoded-bundle struct typedef.
REQ-036 Combinational decode is one sub-module, decode_comb (Ins -> bundle + IllegalOp, no state); decode_pipe holds handshake, output register and hazard tracking.

Verification
REQ-037 Reset: Rst=1 two cycles with InValid=1 -> OutValid=0, InReady=0, all outputs 0.
REQ-038 Streaming: OutReady=1, ADD R2 then LD_IMD 0x5A back-to-back -> bundles on consecutive cycles, ALUCode 0 then ALU_LD, Carry_CE 1 then 0, Data=0x5A.
REQ-039 Backpressure: OutReady=0 three cycles after SUB R1 -> bundle stable, InReady=0, next Ins accepted cycle OutReady=1.
REQ-040 Hazard, DM_WR_LAT=2: ST_DM 0x10 then LD_DM 0x10 -> HazardStall high until PendCnt=0, LD_DM accepted 2 cycles after store handshake; LD_DM 0x11 accepted without stall.
REQ-041 Illegal/flush: section-3 rest 6 -> IllegalOp=1, enables 0; Flush with held ST_DM -> OutValid=0 next cycle, following LD_DM same address not stalled.
REQ-042 Parameter sweep: NUM_REGS=16, DATA_W=12 -> RegAddr one-hot over 16 bits for RNum 0..15, Data carries full 12 bits.

Source files
------------

// File: rtl/decode_pipe_pkg.sv
// Shared encodings and the decoded control bundle for the decode pipeline.
package decode_pipe_pkg;

    typedef enum logic [1:0] {
        SEC_R    = 2'd0,
        SEC_DM   = 2'd1,
        SEC_IMD  = 2'd2,
        SEC_REST = 2'd3
    } sec_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_LD  = 3'd6,
        ALU_DEF = 3'd7
    } alu_e;

    // Low opcode bits when the section is SEC_REST.
    typedef enum logic [2:0] {
        LD_R   = 3'd0,
        LD_DM  = 3'd1,
        LD_IMD = 3'd2,
        ST_R   = 3'd3,
        ST_DM  = 3'd4
    } rest_e;

    localparam rest_e LAST_LD_INS = LD_IMD;

    typedef struct packed {
        logic dm_we;
        logic reg_ce;
        logic carry_ce;
        logic accu_ce;
        sec_e sel;
        alu_e alu;
    } ctrl_t;

    function automatic logic is_dm_read(input logic [4:0] opcode);
        return (opcode[4:3] == SEC_DM) || (opcode == {SEC_REST, LD_DM});
    endfunction

endpackage

// File: rtl/decode_pipe_comb.sv
// Stateless instruction decoder: instruction word to control bundle plus illegal flag.
module decode_comb
    import decode_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_REGS = 4,
    localparam int RSEL_W = $clog2(NUM_REGS),
    localparam int INS_W = 5 + RSEL_W + DATA_W
) (
    input  logic [INS_W-1:0]    i_ins,
    output ctrl_t               o_ctrl,
    output logic [NUM_REGS-1:0] o_reg_addr,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_illegal_op
);

    logic [1:0]        w_section;
    logic [2:0]        w_rest;
    logic [RSEL_W-1:0] w_rnum;

    assign w_section  = i_ins[INS_W-1 -: 2];
    assign w_rest     = i_ins[INS_W-3 -: 3];
    assign w_rnum     = i_ins[DATA_W +: RSEL_W];
    assign o_data     = i_ins[DATA_W-1:0];
    assign o_reg_addr = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_rnum;

    always_comb begin
        o_ctrl       = '0;
        o_ctrl.sel   = SEC_R;
        o_ctrl.alu   = ALU_DEF;
        o_illegal_op = 1'b0;
        if (w_section != SEC_REST) begin
            if (w_rest <= ALU_NOT) begin
                o_ctrl.alu      = alu_e'(w_rest);
                o_ctrl.sel      = sec_e'(w_section);
                o_ctrl.accu_ce  = 1'b1;
                o_ctrl.carry_ce = (w_rest <= ALU_SUB);
            end else begin
                o_illegal_op = 1'b1;
            end
        end else if (w_rest <= LAST_LD_INS) begin
            // Load opcodes share their operand-source encoding with the section codes.
            o_ctrl.alu     = ALU_LD;
            o_ctrl.sel     = sec_e'(w_rest[1:0]);
            o_ctrl.accu_ce = 1'b1;
        end else if (w_rest == ST_R) begin
            o_ctrl.sel    = SEC_DM;
            o_ctrl.reg_ce = 1'b1;
        end else if (w_rest == ST_DM) begin
            o_ctrl.dm_we = 1'b1;
        end else begin
            o_illegal_op = 1'b1;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: one output register with valid/ready handshake, flush, and
// stalling of data-memory reads that would overtake an in-flight store.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_REGS = 4,
    parameter int DM_WR_LAT = 1,
    localparam int RSEL_W = $clog2(NUM_REGS),
    localparam int INS_W = 5 + RSEL_W + DATA_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [INS_W-1:0]    i_ins,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic                i_flush,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic                o_dm_we,
    output logic                o_reg_ce,
    output logic                o_carry_ce,
    output logic                o_accu_ce,
    output logic [NUM_REGS-1:0] o_reg_addr,
    output logic [DATA_W-1:0]   o_data,
    output logic [1:0]          o_sel_data_source,
    output logic [2:0]          o_alu_code,
    output logic                o_illegal_op,
    output logic                o_hazard_stall
);

    ctrl_t               w_ctrl;
    logic [NUM_REGS-1:0] w_reg_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_illegal;
    logic                w_hazard;
    logic                w_load;
    logic                w_store_commit;

    ctrl_t               r_ctrl;
    logic [NUM_REGS-1:0] r_reg_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_illegal;
    logic                r_out_valid;
    logic [2:0]          r_pend_cnt;
    logic [DATA_W-1:0]   r_pend_addr;

    decode_comb #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_decode_comb (
        .i_ins        (i_ins),
        .o_ctrl       (w_ctrl),
        .o_reg_addr   (w_reg_addr),
        .o_data       (w_data),
        .o_illegal_op (w_illegal)
    );

    // A read must wait for both a store still in the output register and one draining.
    assign w_hazard = i_in_valid && is_dm_read(i_ins[INS_W-1 -: 5]) &&
                      (((r_pend_cnt != 3'd0) && (w_data == r_pend_addr)) ||
                       (r_out_valid && r_ctrl.dm_we && (w_data == r_data)));

    assign o_in_ready     = !i_rst && (!r_out_valid || i_out_ready) && !i_flush && !w_hazard;
    assign w_load         = i_in_valid && o_in_ready;
    assign w_store_commit = r_out_valid && i_out_ready && r_ctrl.dm_we && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_reg_addr  <= '0;
            r_data      <= '0;
            r_illegal   <= 1'b0;
            r_pend_cnt  <= 3'd0;
            r_pend_addr <= '0;
        end else begin
            if (w_load) begin
                r_ctrl     <= w_ctrl;
                r_reg_addr <= w_reg_addr;
                r_data     <= w_data;
                r_illegal  <= w_illegal;
            end
            if (i_flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_store_commit) begin
                r_pend_cnt  <= 3'(DM_WR_LAT);
                r_pend_addr <= r_data;
            end else if (r_pend_cnt != 3'd0) begin
                r_pend_cnt <= r_pend_cnt - 3'd1;
            end
        end
    end

    assign o_out_valid       = r_out_valid;
    assign o_dm_we           = r_out_valid && r_ctrl.dm_we;
    assign o_reg_ce          = r_out_valid && r_ctrl.reg_ce;
    assign o_carry_ce        = r_out_valid && r_ctrl.carry_ce;
    assign o_accu_ce         = r_out_valid && r_ctrl.accu_ce;
    assign o_reg_addr        = r_reg_addr;
    assign o_data            = r_data;
    assign o_sel_data_source = r_ctrl.sel;
    assign o_alu_code        = r_ctrl.alu;
    assign o_illegal_op      = r_illegal;
    assign o_hazard_stall    = w_hazard;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: default build with DM_WR_LAT=2 plus a wide-parameter build.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] ins;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic        dm_we, reg_ce, carry_ce, accu_ce, illegal, hazard;
    logic [3:0]  reg_addr;
    logic [7:0]  data;
    logic [1:0]  sel;
    logic [2:0]  alu;

    logic [20:0] s_ins;
    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic        s_dm_we, s_reg_ce, s_carry_ce, s_accu_ce, s_illegal, s_hazard;
    logic [15:0] s_reg_addr;
    logic [11:0] s_data;
    logic [1:0]  s_sel;
    logic [2:0]  s_alu;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_pipe #(.DATA_W(8), .NUM_REGS(4), .DM_WR_LAT(2)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ins(ins), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_flush(flush), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_dm_we(dm_we),
        .o_reg_ce(reg_ce), .o_carry_ce(carry_ce), .o_accu_ce(accu_ce), .o_reg_addr(reg_addr),
        .o_data(data), .o_sel_data_source(sel), .o_alu_code(alu), .o_illegal_op(illegal),
        .o_hazard_stall(hazard)
    );

    decode_pipe #(.DATA_W(12), .NUM_REGS(16), .DM_WR_LAT(1)) u_dut_wide (
        .i_clk(clk), .i_rst(rst), .i_ins(s_ins), .i_in_valid(s_in_valid),
        .o_in_ready(s_in_ready), .i_flush(s_flush), .o_out_valid(s_out_valid),
        .i_out_ready(s_out_ready), .o_dm_we(s_dm_we), .o_reg_ce(s_reg_ce),
        .o_carry_ce(s_carry_ce), .o_accu_ce(s_accu_ce), .o_reg_addr(s_reg_addr),
        .o_data(s_data), .o_sel_data_source(s_sel), .o_alu_code(s_alu),
        .o_illegal_op(s_illegal), .o_hazard_stall(s_hazard)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input logic ov, input logic we, input logic rce,
                              input logic cce, input logic ace, input logic [3:0] ra,
                              input logic [7:0] d, input logic [1:0] s, input logic [2:0] a,
                              input logic ill);
        chk({tag, ".ov"}, out_valid, ov);
        chk({tag, ".dm_we"}, dm_we, we);
        chk({tag, ".reg_ce"}, reg_ce, rce);
        chk({tag, ".carry_ce"}, carry_ce, cce);
        chk({tag, ".accu_ce"}, accu_ce, ace);
        chk({tag, ".reg_addr"}, reg_addr, ra);
        chk({tag, ".data"}, data, d);
        chk({tag, ".sel"}, sel, s);
        chk({tag, ".alu"}, alu, a);
        chk({tag, ".illegal"}, illegal, ill);
    endtask

    function automatic logic [14:0] mk(input logic [1:0] s, input logic [2:0] r,
                                       input logic [1:0] rn, input logic [7:0] d);
        return {s, r, rn, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; ins = mk(2'd0, 3'd0, 2'd2, 8'h03);
        flush = 1'b0; out_ready = 1'b1;
        s_ins = '0; s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;

        // Reset held two cycles with valid input.
        @(negedge clk);
        chk("rst.in_ready0", in_ready, 1'b0);
        tick();
        @(negedge clk);
        chk_bundle("rst", 0, 0, 0, 0, 0, 4'h0, 8'h00, 2'd0, 3'd0, 0);
        chk("rst.in_ready1", in_ready, 1'b0);
        chk("rst.hazard", hazard, 1'b0);
        chk("rst.wide_ov", s_out_valid, 1'b0);
        tick();

        // Streaming: ADD R2, LD_IMD 0x5A, ST_R R1 back to back.
        rst = 1'b0;
        @(negedge clk);
        chk("str.rdy0", in_ready, 1'b1);
        tick();
        ins = mk(2'd3, 3'd2, 2'd0, 8'h5A);
        @(negedge clk);
        chk_bundle("str.add", 1, 0, 0, 1, 1, 4'b0100, 8'h03, 2'd0, 3'd0, 0);
        chk("str.rdy1", in_ready, 1'b1);
        tick();
        ins = mk(2'd3, 3'd3, 2'd1, 8'h05);
        @(negedge clk);
        chk_bundle("str.ldimd", 1, 0, 0, 0, 1, 4'b0001, 8'h5A, 2'd2, 3'd6, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk_bundle("str.str", 1, 0, 1, 0, 0, 4'b0010, 8'h05, 2'd1, 3'd7, 0);
        tick();
        @(negedge clk);
        chk("str.drain", out_valid, 1'b0);
        chk("str.gated_accu", accu_ce, 1'b0);
        tick();

        // Backpressure: SUB R1 held three cycles, then AND from SEC_IMD.
        in_valid = 1'b1; ins = mk(2'd0, 3'd1, 2'd1, 8'h77); out_ready = 1'b0;
        @(negedge clk);
        chk("bp.rdy0", in_ready, 1'b1);
        tick();
        ins = mk(2'd2, 3'd2, 2'd3, 8'h12);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_bundle("bp.hold", 1, 0, 0, 1, 1, 4'b0010, 8'h77, 2'd0, 3'd1, 0);
            chk("bp.rdy", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.rdy1", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk_bundle("bp.and", 1, 0, 0, 0, 1, 4'b1000, 8'h12, 2'd2, 3'd2, 0);
        tick();

        // Hazard: ST_DM 0x10, LD_DM 0x11 passes, LD_DM 0x10 waits for the store to drain.
        in_valid = 1'b1; ins = mk(2'd3, 3'd4, 2'd0, 8'h10);
        @(negedge clk);
        chk("hz.rdy0", in_ready, 1'b1);
        tick();
        ins = mk(2'd3, 3'd1, 2'd0, 8'h11);
        @(negedge clk);
        chk_bundle("hz.st", 1, 1, 0, 0, 0, 4'b0001, 8'h10, 2'd0, 3'd7, 0);
        chk("hz.other_addr_stall", hazard, 1'b0);
        chk("hz.other_addr_rdy", in_ready, 1'b1);
        tick();
        ins = mk(2'd3, 3'd1, 2'd0, 8'h10);
        @(negedge clk);
        chk_bundle("hz.ld11", 1, 0, 0, 0, 1, 4'b0001, 8'h11, 2'd1, 3'd6, 0);
        chk("hz.stall_cnt2", hazard, 1'b1);
        chk("hz.rdy_cnt2", in_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("hz.stall_cnt1", hazard, 1'b1);
        chk("hz.ov_gap", out_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("hz.stall_cnt0", hazard, 1'b0);
        chk("hz.rdy_cnt0", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk_bundle("hz.ld10", 1, 0, 0, 0, 1, 4'b0001, 8'h10, 2'd1, 3'd6, 0);
        tick();

        // Illegal section-3 rest 6, then a held ST_DM flushed away.
        in_valid = 1'b1; ins = mk(2'd3, 3'd6, 2'd1, 8'hAB);
        tick();
        ins = mk(2'd3, 3'd4, 2'd0, 8'h30);
        @(negedge clk);
        chk_bundle("il.rest6", 1, 0, 0, 0, 0, 4'b0010, 8'hAB, 2'd0, 3'd7, 1);
        tick();
        ins = mk(2'd3, 3'd1, 2'd0, 8'h30); out_ready = 1'b0;
        @(negedge clk);
        chk("fl.held_we", dm_we, 1'b1);
        chk("fl.held_stall", hazard, 1'b1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("fl.rdy_flush", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl.ov", out_valid, 1'b0);
        chk("fl.we_gated", dm_we, 1'b0);
        chk("fl.no_stall", hazard, 1'b0);
        chk("fl.rdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk_bundle("fl.ld30", 1, 0, 0, 0, 1, 4'b0001, 8'h30, 2'd1, 3'd6, 0);
        tick();

        // Reset mid-operation drops a draining store.
        in_valid = 1'b1; ins = mk(2'd3, 3'd4, 2'd2, 8'h40);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1; in_valid = 1'b1; ins = mk(2'd3, 3'd1, 2'd0, 8'h40);
        @(negedge clk);
        chk("mr.rdy_rst", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr.ov", out_valid, 1'b0);
        chk("mr.no_stall", hazard, 1'b0);
        chk("mr.rdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk_bundle("mr.ld40", 1, 0, 0, 0, 1, 4'b0001, 8'h40, 2'd1, 3'd6, 0);
        tick();

        // Wide build: one-hot over 16 registers and the full 12-bit data field.
        s_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [11:0] d;
            d = {4'hA, 4'(i), 4'(15 - i)};
            s_ins = {2'd3, 3'd2, 4'(i), d};
            tick();
            chk("sw.ov", s_out_valid, 1'b1);
            chk("sw.reg_addr", s_reg_addr, 32'd1 << i);
            chk("sw.data", s_data, d);
            chk("sw.alu", s_alu, 3'd6);
        end
        s_in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
